hazard_fwd_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage MIPS core. It compares the ID-stage source registers against the destination registers of the instructions in EX, MEM and WB. From that it generates registered forwarding selects for the EX operand muxes and for the MEM-stage store-data mux. It also produces the IF/ID stall and EX-flush for load-use hazards, and times the multi-cycle multiply/divide unit (MDU) so that HI/LO readers and back-to-back MDU ops wait for it.

---
 rtl/hazard_pkg.sv | 50 +++++
 rtl/mdu_busy_timer.sv | 72 +++++++
 rtl/hazard_fwd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared constants, types and small helpers for the hazard/forwarding
//   controller of the 5-stage MIPS core.
//
//   Contents:
//     FWD_REG / FWD_MEM / FWD_WB : EX operand-mux select encodings
//     mdu_state_e               : MDU busy-timer FSM states
//     REG_ZERO                  : architectural register $0 (never forwarded)
//     reg_hit()                 : destination/source compare with $0 masking
//     fwd_select()              : priority encoder for one operand select
// -----------------------------------------------------------------------------
package hazard_pkg;

   // Operand select encodings. 2'b11 is never produced.
   localparam logic [1:0] FWD_REG = 2'b00;  // register file value
   localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result now held in MEM
   localparam logic [1:0] FWD_WB  = 2'b10;  // write-back data now in WB

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   // A producer matches a consumer only if it really writes, targets the same
   // register, and that register is not $0 (writes to $0 are discarded).
   function automatic logic reg_hit(input logic       we,
                                    input logic [4:0] dst,
                                    input logic [4:0] src);
      return we && (dst == src) && (dst != REG_ZERO);
   endfunction

   // The younger producer (EX) wins over the older one (MEM). A load in EX
   // cannot supply data from its ALU result, so it never selects FWD_MEM.
   function automatic logic [1:0] fwd_select(input logic ex_hit,
                                             input logic ex_load,
                                             input logic mem_hit);
      logic [1:0] sel;
      sel = FWD_REG;
      if (ex_hit && !ex_load) begin
         sel = FWD_MEM;
      end else if (mem_hit) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage : hazard_pkg

// File: rtl/mdu_busy_timer.sv
// -----------------------------------------------------------------------------
// mdu_busy_timer
//   Tracks the latency of the multi-cycle multiply/divide unit. A start pulse
//   in IDLE moves the FSM to BUSY and loads MDU_LAT-1 into the down-counter;
//   BUSY lasts exactly MDU_LAT cycles (counter values MDU_LAT-1 .. 0) and the
//   FSM returns to IDLE on the edge that sees the counter at 0.
//
//   Parameters:
//     MDU_LAT : cycles from MDU start to HI/LO valid (must be >= 2)
//   Ports:
//     clk   in  : clock, rising edge
//     rst_n in  : synchronous active-low reset
//     start in  : MDU operation accepted this cycle (ignored while BUSY)
//     busy  out : MDU result not yet valid (FSM state == BUSY)
// -----------------------------------------------------------------------------
module mdu_busy_timer
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy
);

   localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   mdu_state_e    state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         MDU_IDLE: begin
            if (start) begin
               state_d = MDU_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         MDU_BUSY: begin
            // The cycle with counter 0 is still busy; HI/LO becomes valid
            // in the following (IDLE) cycle.
            if (cnt_q == '0) begin
               state_d = MDU_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == MDU_BUSY);

endmodule : mdu_busy_timer

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard detection and forwarding control for the 5-stage MIPS pipeline.
//   Compares the ID source registers with the EX/MEM/WB destinations and
//   produces:
//     - registered EX operand selects (valid during the instruction's EX cycle)
//     - a registered MEM store-data select
//     - combinational WB->ID register-file bypass flags
//     - combinational load-use / MDU stall and EX flush
//   The MDU latency is tracked by the mdu_busy_timer sub-module.
//
//   Optional build macro: HAZARD_STALL_CNT_EN adds a 32-bit free-running
//   stall_cnt output counting cycles with stall_id = 1.
//
//   Stall handshake: when stall_id is 1 the ID instruction does not advance
//   (PC and IF/ID hold, ID/EX receives a bubble); an instruction advances from
//   ID to EX only on an edge where stall_id is 0.
//
//   Ports:
//     clk, rst_n                      : clock, synchronous active-low reset
//     id_*                            : ID-stage instruction decode info
//     ex_wbadd/ex_regwrite/ex_memread : EX destination, write enable, load
//     ex_rt/ex_is_store               : EX store-data register and store flag
//     mem_wbadd/mem_regwrite          : MEM destination and write enable
//     wb_wbadd/wb_regwrite            : WB destination and write enable
//     fwd_a_sel/fwd_b_sel             : registered EX rs/rt operand selects
//     mem_rt_fwd                      : registered MEM store-data select
//     id_byp_rs/id_byp_rt             : WB->ID bypass flags
//     stall_if/stall_id/flush_ex      : hazard stall and bubble insertion
//     mdu_busy                        : MDU result not yet valid
//     stall_cnt (optional)            : stall cycle counter
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       id_is_store,
   input  logic       id_mdu_start,
   input  logic       id_reads_hilo,
   input  logic [4:0] ex_wbadd,
   input  logic       ex_regwrite,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       ex_is_store,
   input  logic [4:0] mem_wbadd,
   input  logic       mem_regwrite,
   input  logic [4:0] wb_wbadd,
   input  logic       wb_regwrite,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       mem_rt_fwd,
   output logic       id_byp_rs,
   output logic       id_byp_rt,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_ex,
   output logic       mdu_busy
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic       rs_ex_hit, rt_ex_hit;
   logic       rs_mem_hit, rt_mem_hit;
   logic       rs_ld_match, rt_ld_match;
   logic       ld_haz, mdu_haz, stall;
   logic       mdu_accept;
   logic       mdu_busy_w;

   logic [1:0] fwd_a_d, fwd_a_q;
   logic [1:0] fwd_b_d, fwd_b_q;
   logic       mem_rt_fwd_d, mem_rt_fwd_q;

   // ---------------------------------------------------------------------
   // Register compares
   // ---------------------------------------------------------------------
   assign rs_ex_hit  = reg_hit(ex_regwrite,  ex_wbadd,  id_rs);
   assign rt_ex_hit  = reg_hit(ex_regwrite,  ex_wbadd,  id_rt);
   assign rs_mem_hit = reg_hit(mem_regwrite, mem_wbadd, id_rs);
   assign rt_mem_hit = reg_hit(mem_regwrite, mem_wbadd, id_rt);

   // WB writes the register file in the first half of the cycle in spirit;
   // this bypass lets ID read the value being written this cycle.
   assign id_byp_rs = reg_hit(wb_regwrite, wb_wbadd, id_rs);
   assign id_byp_rt = reg_hit(wb_regwrite, wb_wbadd, id_rt);

   // ---------------------------------------------------------------------
   // Hazards
   // ---------------------------------------------------------------------
   // A load in EX has no data until the end of MEM, so a dependent EX use
   // must wait one cycle. A store that needs the loaded value only as store
   // data can proceed: the value is forwarded into MEM via mem_rt_fwd.
   assign rs_ld_match = id_uses_rs && (id_rs == ex_wbadd);
   assign rt_ld_match = id_uses_rt && (id_rt == ex_wbadd) && !id_is_store;

   assign ld_haz = id_valid && ex_memread && (ex_wbadd != REG_ZERO) &&
                   (rs_ld_match || rt_ld_match);

   // HI/LO readers and a second MDU op wait until the MDU has finished.
   assign mdu_haz = id_valid && mdu_busy_w && (id_reads_hilo || id_mdu_start);

   assign stall    = ld_haz || mdu_haz;
   assign stall_if = stall;
   assign stall_id = stall;
   assign flush_ex = stall;

   // An MDU op is launched only when it actually leaves ID.
   assign mdu_accept = id_mdu_start && id_valid && !stall;

   mdu_busy_timer #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu_busy_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mdu_accept),
      .busy  (mdu_busy_w)
   );

   assign mdu_busy = mdu_busy_w;

   // ---------------------------------------------------------------------
   // Forwarding selects
   // ---------------------------------------------------------------------
   // On a stall edge a bubble enters EX, so the selects are forced to the
   // register file; the stalled instruction recomputes them next cycle.
   always_comb begin
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
      if (!stall) begin
         fwd_a_d = fwd_select(rs_ex_hit, ex_memread, rs_mem_hit);
         fwd_b_d = fwd_select(rt_ex_hit, ex_memread, rt_mem_hit);
      end
   end

   // The store now in EX reaches MEM next cycle while its producer (in MEM
   // now) reaches WB, so store data is taken from the WB write data.
   assign mem_rt_fwd_d = ex_is_store && reg_hit(mem_regwrite, mem_wbadd, ex_rt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_a_q      <= FWD_REG;
         fwd_b_q      <= FWD_REG;
         mem_rt_fwd_q <= 1'b0;
      end else begin
         fwd_a_q      <= fwd_a_d;
         fwd_b_q      <= fwd_b_d;
         mem_rt_fwd_q <= mem_rt_fwd_d;
      end
   end

   assign fwd_a_sel  = fwd_a_q;
   assign fwd_b_sel  = fwd_b_q;
   assign mem_rt_fwd = mem_rt_fwd_q;

   // ---------------------------------------------------------------------
   // Optional stall statistics
   // ---------------------------------------------------------------------
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;

   // Wraps naturally modulo 2^32.
   assign stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule : hazard_fwd_ctrl

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed bench for hazard_fwd_ctrl (MDU_LAT = 4). Single-cycle compare
//   cases come from a vector table; load-use, store forwarding, MDU timing,
//   reset during MDU busy and simultaneous hazards are hand-written sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_fwd_ctrl;

   localparam int LAT = 4;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // DUT
   // ---------------------------------------------------------------------
   logic       id_valid, id_uses_rs, id_uses_rt, id_is_store;
   logic       id_mdu_start, id_reads_hilo;
   logic [4:0] id_rs, id_rt, ex_wbadd, ex_rt, mem_wbadd, wb_wbadd;
   logic       ex_regwrite, ex_memread, ex_is_store, mem_regwrite, wb_regwrite;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       mem_rt_fwd, id_byp_rs, id_byp_rt;
   logic       stall_if, stall_id, flush_ex, mdu_busy;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   hazard_fwd_ctrl #(.MDU_LAT(LAT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .id_is_store   (id_is_store),
      .id_mdu_start  (id_mdu_start),
      .id_reads_hilo (id_reads_hilo),
      .ex_wbadd      (ex_wbadd),
      .ex_regwrite   (ex_regwrite),
      .ex_memread    (ex_memread),
      .ex_rt         (ex_rt),
      .ex_is_store   (ex_is_store),
      .mem_wbadd     (mem_wbadd),
      .mem_regwrite  (mem_regwrite),
      .wb_wbadd      (wb_wbadd),
      .wb_regwrite   (wb_regwrite),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .mem_rt_fwd    (mem_rt_fwd),
      .id_byp_rs     (id_byp_rs),
      .id_byp_rt     (id_byp_rt),
      .stall_if      (stall_if),
      .stall_id      (stall_id),
      .flush_ex      (flush_ex),
      .mdu_busy      (mdu_busy)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   // ---------------------------------------------------------------------
   // Scoreboard counters and compare
   // ---------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_stall(input string nm, input logic exp);
      check({nm, "_stall_if"}, {31'd0, stall_if}, {31'd0, exp});
      check({nm, "_stall_id"}, {31'd0, stall_id}, {31'd0, exp});
      check({nm, "_flush_ex"}, {31'd0, flush_ex}, {31'd0, exp});
   endtask

   // ---------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------
   typedef struct {
      logic       v;
      logic [4:0] rs, rt;
      logic       urs, urt, st;
      logic [4:0] exw;
      logic       exr, exm;
      logic [4:0] ert;
      logic       est;
      logic [4:0] mw;
      logic       mr;
      logic [4:0] ww;
      logic       wr;
      logic       e_stall, e_brs, e_brt;
      logic [1:0] e_fa, e_fb;
      logic       e_mrf;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int st,
                               int exw, int exr, int exm, int ert, int est,
                               int mw, int mr, int ww, int wr,
                               int es, int ebrs, int ebrt, int efa, int efb, int emrf);
      vec_t m;
      m.v = 1'(v);   m.rs = 5'(rs);   m.rt = 5'(rt);
      m.urs = 1'(urs); m.urt = 1'(urt); m.st = 1'(st);
      m.exw = 5'(exw); m.exr = 1'(exr); m.exm = 1'(exm);
      m.ert = 5'(ert); m.est = 1'(est);
      m.mw = 5'(mw); m.mr = 1'(mr); m.ww = 5'(ww); m.wr = 1'(wr);
      m.e_stall = 1'(es); m.e_brs = 1'(ebrs); m.e_brt = 1'(ebrt);
      m.e_fa = 2'(efa); m.e_fb = 2'(efb); m.e_mrf = 1'(emrf);
      return m;
   endfunction

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   task automatic clear_in();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_is_store = 0; id_mdu_start = 0; id_reads_hilo = 0;
      ex_wbadd = 0; ex_regwrite = 0; ex_memread = 0; ex_rt = 0; ex_is_store = 0;
      mem_wbadd = 0; mem_regwrite = 0; wb_wbadd = 0; wb_regwrite = 0;
   endtask

   task automatic drive(input vec_t x);
      clear_in();
      id_valid = x.v; id_rs = x.rs; id_rt = x.rt;
      id_uses_rs = x.urs; id_uses_rt = x.urt; id_is_store = x.st;
      ex_wbadd = x.exw; ex_regwrite = x.exr; ex_memread = x.exm;
      ex_rt = x.ert; ex_is_store = x.est;
      mem_wbadd = x.mw; mem_regwrite = x.mr;
      wb_wbadd = x.ww; wb_regwrite = x.wr;
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_fwd_a"}, {30'd0, fwd_a_sel}, 32'd0);
      check({nm, "_fwd_b"}, {30'd0, fwd_b_sel}, 32'd0);
      check({nm, "_mem_rt_fwd"}, {31'd0, mem_rt_fwd}, 32'd0);
      check({nm, "_byp"}, {30'd0, id_byp_rs, id_byp_rt}, 32'd0);
      check_stall(nm, 1'b0);
      check({nm, "_mdu_busy"}, {31'd0, mdu_busy}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
      check({nm, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
   endtask

   // ---------------------------------------------------------------------
   // Test
   // ---------------------------------------------------------------------
   int stall_n, busy_n;
   logic released;

   initial begin
      //        v rs rt us ut st exw er em ert es mw mr ww wr | st brs brt fa fb mrf
      vecs[0]  = mk(1, 8, 3, 1, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // EX fwd rs
      vecs[1]  = mk(1, 8, 3, 1, 1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 2, 0, 0); // MEM fwd rs
      vecs[2]  = mk(1, 8, 3, 1, 1, 0, 8, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0); // EX priority
      vecs[3]  = mk(1, 4, 5, 1, 1, 0, 4, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 2, 0); // rs EX, rt MEM
      vecs[4]  = mk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); // $0 never hits
      vecs[5]  = mk(1, 7, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0); // WB byp rs
      vecs[6]  = mk(1, 6, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 1, 1, 0, 0, 0); // WB byp both
      vecs[7]  = mk(1, 6, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0); // WB no write
      vecs[8]  = mk(1, 8, 3, 1, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // EX no write
      vecs[9]  = mk(1, 9, 3, 1, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // load-use rs
      vecs[10] = mk(1, 9, 3, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // rs not used
      vecs[11] = mk(0, 9, 3, 1, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // ID invalid
      vecs[12] = mk(1, 2, 9, 1, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // store rt only
      vecs[13] = mk(1, 9, 2, 1, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // store rs dep
      vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1); // mem_rt_fwd
      vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); // store $0
      vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0); // not store
      vecs[17] = mk(1, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // load to $0
      vecs[18] = mk(1, 3, 9, 1, 1, 0, 9, 1, 1, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 0, 0); // stall forces 00

      // Reset state
      rst_n = 1'b0;
      clear_in();
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      // Table-driven single-cycle cases
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check_stall($sformatf("v%0d", i), vecs[i].e_stall);
         check($sformatf("v%0d_byp_rs", i), {31'd0, id_byp_rs}, {31'd0, vecs[i].e_brs});
         check($sformatf("v%0d_byp_rt", i), {31'd0, id_byp_rt}, {31'd0, vecs[i].e_brt});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_fwd_a", i), {30'd0, fwd_a_sel}, {30'd0, vecs[i].e_fa});
         check($sformatf("v%0d_fwd_b", i), {30'd0, fwd_b_sel}, {30'd0, vecs[i].e_fb});
         check($sformatf("v%0d_mem_rt_fwd", i), {31'd0, mem_rt_fwd}, {31'd0, vecs[i].e_mrf});
      end

      // Load-use: EX lw $9, ID add rt=$9 -> one stall, then select WB
      @(negedge clk);
      clear_in();
      id_valid = 1; id_rs = 1; id_rt = 9; id_uses_rs = 1; id_uses_rt = 1;
      ex_wbadd = 9; ex_regwrite = 1; ex_memread = 1;
      #1 check_stall("lu_c1", 1'b1);
      @(posedge clk);
      #1 check("lu_c1_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
      @(negedge clk);
      ex_wbadd = 0; ex_regwrite = 0; ex_memread = 0;
      mem_wbadd = 9; mem_regwrite = 1;
      #1 check_stall("lu_c2", 1'b0);
      @(posedge clk);
      #1 check("lu_c2_fwd_b", {30'd0, fwd_b_sel}, 32'd2);

      // Store after load: no stall, mem_rt_fwd two cycles later
      @(negedge clk);
      clear_in();
      id_valid = 1; id_rs = 2; id_rt = 9; id_uses_rs = 1; id_uses_rt = 1; id_is_store = 1;
      ex_wbadd = 9; ex_regwrite = 1; ex_memread = 1;
      #1 check_stall("st_c1", 1'b0);
      @(posedge clk);
      #1 check("st_c1_mem_rt_fwd", {31'd0, mem_rt_fwd}, 32'd0);
      @(negedge clk);
      clear_in();
      ex_is_store = 1; ex_rt = 9;
      mem_wbadd = 9; mem_regwrite = 1;
      @(posedge clk);
      #1 check("st_c2_mem_rt_fwd", {31'd0, mem_rt_fwd}, 32'd1);

      // MDU: MULT accepted, one independent instruction, then MFHI.
      // Busy lasts LAT cycles; the MFHI enters in the second busy cycle and
      // waits for the remaining LAT-1 cycles.
      @(negedge clk);
      clear_in();
      id_valid = 1; id_mdu_start = 1;
      #1 check_stall("mult_c0", 1'b0);
      check("mult_c0_busy", {31'd0, mdu_busy}, 32'd0);
      @(posedge clk);
      busy_n = 0; stall_n = 0; released = 1'b0;
      @(negedge clk);
      clear_in();
      id_valid = 1;
      #1 check("mult_c1_busy", {31'd0, mdu_busy}, 32'd1);
      if (mdu_busy) busy_n++;
      @(posedge clk);
      for (int c = 0; c < 12 && !released; c++) begin
         @(negedge clk);
         clear_in();
         id_valid = 1; id_reads_hilo = 1;
         #1;
         if (mdu_busy) busy_n++;
         if (stall_id) stall_n++;
         else released = 1'b1;
         @(posedge clk);
      end
      check("mfhi_released", {31'd0, released}, 32'd1);
      check("mfhi_stall_cycles", stall_n, LAT - 1);
      check("mdu_busy_cycles", busy_n, LAT);

      // Back-to-back MDU ops: the second waits LAT cycles, then is accepted
      @(negedge clk);
      clear_in();
      id_valid = 1; id_mdu_start = 1;
      @(posedge clk);
      stall_n = 0; released = 1'b0;
      for (int c = 0; c < 12 && !released; c++) begin
         @(negedge clk);
         #1;
         if (stall_id) stall_n++;
         else released = 1'b1;
         @(posedge clk);
      end
      check("mdu2_stall_cycles", stall_n, LAT);
      @(negedge clk);
      clear_in();
      #1 check("mdu2_accepted_busy", {31'd0, mdu_busy}, 32'd1);

      // Reset while busy
      rst_n = 1'b0;
      @(posedge clk);
      #1 check_all_zero("rst_mid");
      @(negedge clk) rst_n = 1'b1;

      // Load-use and MDU start together: one stall, start not accepted;
      // next cycle the load is in MEM, the MULT goes and rs selects WB.
      @(negedge clk);
      clear_in();
      id_valid = 1; id_mdu_start = 1; id_rs = 9; id_uses_rs = 1;
      ex_wbadd = 9; ex_regwrite = 1; ex_memread = 1;
      #1 check_stall("sim_c1", 1'b1);
      @(posedge clk);
      #1 check("sim_c1_busy", {31'd0, mdu_busy}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
      check("stall_cnt_one", stall_cnt, 32'd1);
`endif
      @(negedge clk);
      ex_wbadd = 0; ex_regwrite = 0; ex_memread = 0;
      mem_wbadd = 9; mem_regwrite = 1;
      #1 check_stall("sim_c2", 1'b0);
      @(posedge clk);
      #1 check("sim_c2_busy", {31'd0, mdu_busy}, 32'd1);
      check("sim_c2_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
      @(negedge clk);
      clear_in();
      // HI/LO reader while the MDU runs and a load-use at the same time
      id_valid = 1; id_reads_hilo = 1; id_rs = 5; id_uses_rs = 1;
      ex_wbadd = 5; ex_regwrite = 1; ex_memread = 1;
      #1 check_stall("sim_c3", 1'b1);
      @(posedge clk);
`ifdef HAZARD_STALL_CNT_EN
      #1 check("stall_cnt_two", stall_cnt, 32'd2);
`endif

      @(negedge clk);
      clear_in();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule : tb_hazard_fwd_ctrl
